dcache_line_writer: RTL
=======================

// Module: dcache_line_writer
// PURPOSE
// Write side of the data-cache line array: owns 16 x 128-bit line registers and per-line valid bits.
// Assembles refill blocks from 32-bit memory beats, and applies byte-masked CPU store words.
// The flattened line bus feeds the 16:1 128-bit line-select mux on the read side.
// PARAMETERS
// NUM_LINES   16   number of cache lines; index width = clog2(NUM_LINES) = 4
// LINE_WIDTH  128  bits per line
// WORD_WIDTH  32   bits per memory beat / CPU word; beats per line = LINE_WIDTH/WORD_WIDTH = 4
// PORTS
// CLK            in   1     clock, rising edge
// RESET          in   1     asynchronous, active-low reset
// FILL_START     in   1     request refill of line FILL_INDEX
// FILL_INDEX     in   4     target line for refill, sampled with FILL_START
// MEM_VALID      in   1     MEM_READDATA carries next refill beat
// MEM_READDATA   in   32    refill beat data
// CPU_WRITE      in   1     CPU store request
// CPU_INDEX      in   4     store target line
// CPU_OFFSET     in   2     word within line
// CPU_BYTEEN     in   4     byte enables, bit b -> bits [8b+7:8b] of the word
// CPU_WRITEDATA  in   32    store data
// FILL_BUSY      out  1     refill in progress (state FILL)
// FILL_DONE      out  1     one-cycle pulse after refilled line is written
// CPU_STALL      out  1     CPU_WRITE not accepted this cycle
// LINE_VALID     out  16    per-line valid bits
// LINES          out  2048  line i on bits [128i+127:128i]
// BEHAVIOUR
// - Reset (RESET low, asynchronous): state IDLE, beat counter 0, all LINES 0, LINE_VALID 0,
//   FILL_BUSY 0, FILL_DONE 0; an in-flight refill is abandoned, its partial data discarded.
// - States: IDLE, FILL, DONE.
//   IDLE: FILL_START=1 -> latch FILL_INDEX, counter<=0, go FILL. Otherwise stay.
//   FILL: each cycle with MEM_VALID=1 writes MEM_READDATA directly into word <counter> of the
//     latched line (bits [32k+31:32k]); counter++. Gaps (MEM_VALID=0) hold state.
//     Accepting beat 3: also set LINE_VALID[idx]=1, go DONE.
//     LINE_VALID[idx] is cleared on the edge FILL is entered, so a partially filled line
//     never reads as valid.
//   DONE: FILL_DONE=1 for exactly this cycle, then IDLE. FILL_START here is ignored.
// - FILL_START outside IDLE ignored; MEM_VALID outside FILL ignored.
// - FILL_BUSY = (state==FILL). FILL_DONE registered (state==DONE). Minimum refill: 1 + 4 cycles
//   from FILL_START edge to FILL_DONE.
// - CPU store: accepted when CPU_WRITE=1 and NOT (state==FILL and CPU_INDEX==latched idx);
//   otherwise CPU_STALL=CPU_WRITE (combinational). Accepted store updates enabled bytes of word
//   CPU_OFFSET of line CPU_INDEX at the edge; other bytes/words unchanged; LINE_VALID unchanged.
// - Simultaneous FILL_START and CPU store in IDLE, same index: store applies and the line
//   still becomes invalid; later refill beats overwrite it.
// - Simultaneous refill beat and accepted store: different lines by construction, both apply.
// - CPU_BYTEEN=0 is accepted as a no-op store.
// - LINES/LINE_VALID are pure register outputs; no combinational path from inputs.
// STRUCTURE
// - Shared package dcache_pkg: NUM_LINES, LINE_WIDTH, WORD_WIDTH, BEATS_PER_LINE, index/offset
//   widths, state encoding localparams (IDLE=2'd0, FILL=2'd1, DONE=2'd2).
// - One sub-module: dcache_word_merge (32-bit old word, new word, 4-bit byte enable -> merged
//   word), combinational; instantiated once on the CPU store path.
// - Line array as 16 registers with per-line write enables; FSM + 2-bit beat counter at top.
// TESTING
// - Reset mid-fill: FILL_START idx 5, 2 beats, drop RESET -> LINES all 0, LINE_VALID 0, FILL_BUSY 0.
// - Refill idx 3, beats 0x11111111,0x22222222,0x33333333,0x44444444 with a 2-cycle gap after beat 1
//   -> line 3 = 0x44444444_33333333_22222222_11111111, LINE_VALID=16'h0008, one FILL_DONE pulse.
// - Store idx 3 offset 2 BYTEEN 4'b0101 data 0xAABBCCDD on filled line 3
//   -> line 3 word 2 = 0x33BB33DD, others unchanged, CPU_STALL 0.
// - During refill of idx 7: store to idx 7 -> CPU_STALL 1, line unchanged; store to idx 8
//   -> accepted same cycle as a refill beat, both lines updated.
// - FILL_START while busy (idx 9) -> ignored, refill of original index completes, line 9 untouched;
//   MEM_VALID in IDLE -> no line changes.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache line writer: geometry, derived
// index/offset widths, refill FSM state type and a word-position helper.
package dcache_pkg;

    localparam int unsigned NUM_LINES      = 16;
    localparam int unsigned LINE_WIDTH     = 128;
    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned BEATS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
    localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / 8;

    localparam int unsigned IDX_W      = $clog2(NUM_LINES);
    localparam int unsigned OFF_W      = $clog2(BEATS_PER_LINE);
    localparam int unsigned LSB_W      = $clog2(LINE_WIDTH);
    localparam int unsigned WORD_SHIFT = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    // Bit position of word 'off' within a line.
    function automatic logic [LSB_W-1:0] word_lsb(input logic [OFF_W-1:0] off);
        return LSB_W'(off) << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Byte-masked word merge for CPU stores.
// Ports:
//   old_word_i  current contents of the target word
//   new_word_i  store data
//   byteen_i    byte enables; bit b selects bits [8b+7:8b] from new_word_i
//   merged_o    resulting word
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [WORD_WIDTH-1:0]     old_word_i,
    input  logic [WORD_WIDTH-1:0]     new_word_i,
    input  logic [BYTES_PER_WORD-1:0] byteen_i,
    output logic [WORD_WIDTH-1:0]     merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
            if (byteen_i[b]) begin
                merged_o[b*8 +: 8] = new_word_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_line_writer.sv
// Write side of the data-cache line array. Holds NUM_LINES line registers
// and per-line valid bits, assembles refill lines from memory beats and
// applies byte-masked CPU stores.
// Ports:
//   CLK, RESET        clock (rising edge), asynchronous active-low reset
//   FILL_START/INDEX  start a refill of line FILL_INDEX (accepted in IDLE only)
//   MEM_VALID/READDATA refill beat, one word per accepted cycle (FILL only)
//   CPU_WRITE/INDEX/OFFSET/BYTEEN/WRITEDATA  CPU store request
//   FILL_BUSY         refill in progress
//   FILL_DONE         one-cycle pulse after the refilled line is complete
//   CPU_STALL         store not accepted this cycle (target line being refilled)
//   LINE_VALID        per-line valid bits (registered)
//   LINES             flattened line array, line i at [LINE_WIDTH*i +: LINE_WIDTH]
module dcache_line_writer
    import dcache_pkg::*;
(
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            FILL_START,
    input  logic [IDX_W-1:0]                FILL_INDEX,
    input  logic                            MEM_VALID,
    input  logic [WORD_WIDTH-1:0]           MEM_READDATA,
    input  logic                            CPU_WRITE,
    input  logic [IDX_W-1:0]                CPU_INDEX,
    input  logic [OFF_W-1:0]                CPU_OFFSET,
    input  logic [BYTES_PER_WORD-1:0]       CPU_BYTEEN,
    input  logic [WORD_WIDTH-1:0]           CPU_WRITEDATA,
    output logic                            FILL_BUSY,
    output logic                            FILL_DONE,
    output logic                            CPU_STALL,
    output logic [NUM_LINES-1:0]            LINE_VALID,
    output logic [NUM_LINES*LINE_WIDTH-1:0] LINES
);

    fill_state_e           state_q, state_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [LINE_WIDTH-1:0] lines_q [NUM_LINES];
    logic [LINE_WIDTH-1:0] lines_d [NUM_LINES];

    logic                  beat_we;
    logic                  last_beat;
    logic                  cpu_accept;
    logic [WORD_WIDTH-1:0] cpu_old_word;
    logic [WORD_WIDTH-1:0] cpu_merged;

    assign beat_we   = (state_q == ST_FILL) && MEM_VALID;
    assign last_beat = (cnt_q == OFF_W'(BEATS_PER_LINE - 1));

    // Only the line currently being refilled blocks stores; a store to it
    // would be overwritten (or leave a half-old line) anyway.
    assign cpu_accept = CPU_WRITE && !((state_q == ST_FILL) && (CPU_INDEX == fill_idx_q));
    assign CPU_STALL  = CPU_WRITE && !cpu_accept;

    assign cpu_old_word = lines_q[CPU_INDEX][word_lsb(CPU_OFFSET) +: WORD_WIDTH];

    dcache_word_merge u_merge (
        .old_word_i (cpu_old_word),
        .new_word_i (CPU_WRITEDATA),
        .byteen_i   (CPU_BYTEEN),
        .merged_o   (cpu_merged)
    );

    // Refill FSM next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_idx_d = fill_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (FILL_START) begin
                    fill_idx_d = FILL_INDEX;
                    cnt_d      = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (MEM_VALID) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Line array and valid next state. A refill beat and an accepted store
    // never target the same line while in FILL, so their order is irrelevant.
    always_comb begin
        lines_d = lines_q;
        valid_d = valid_q;
        if ((state_q == ST_IDLE) && FILL_START) begin
            valid_d[FILL_INDEX] = 1'b0;
        end
        if (beat_we) begin
            lines_d[fill_idx_q][word_lsb(cnt_q) +: WORD_WIDTH] = MEM_READDATA;
            if (last_beat) begin
                valid_d[fill_idx_q] = 1'b1;
            end
        end
        if (cpu_accept) begin
            lines_d[CPU_INDEX][word_lsb(CPU_OFFSET) +: WORD_WIDTH] = cpu_merged;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fill_idx_q <= '0;
            valid_q    <= '0;
            lines_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_idx_q <= fill_idx_d;
            valid_q    <= valid_d;
            lines_q    <= lines_d;
        end
    end

    assign FILL_BUSY  = (state_q == ST_FILL);
    assign FILL_DONE  = (state_q == ST_DONE);
    assign LINE_VALID = valid_q;

    always_comb begin
        LINES = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            LINES[i*LINE_WIDTH +: LINE_WIDTH] = lines_q[i];
        end
    end

endmodule
